// File: rtl/alu_dp_controller_if.sv
// rtl/alu_dp_controller_if.sv - decoded data-processing instruction handshake bundle
interface alu_dp_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cond;
    logic [3:0]  req_opcode;
    logic        req_s;
    logic [3:0]  req_rd;
    logic [31:0] req_rn;
    logic [31:0] req_op2;
    logic        req_shc;

    modport master (
        output req_valid, req_cond, req_opcode, req_s, req_rd, req_rn, req_op2, req_shc,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_cond, req_opcode, req_s, req_rd, req_rn, req_op2, req_shc,
        output req_ready
    );
endinterface

// File: rtl/alu_dp_controller.sv
// rtl/alu_dp_controller.sv - condition check, ALU sequencing, write-back and NZCV ownership
module alu_dp_controller (
    input  logic                       clk,
    input  logic                       reset_n,
    alu_dp_controller_if.slave         req,
    output logic [4:0]                 alu_op,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic                       alu_cin,
    input  logic [31:0]                alu_result,
    input  logic                       alu_z,
    input  logic                       alu_n,
    input  logic                       alu_c,
    input  logic                       alu_v,
    output logic                       wb_valid,
    output logic [3:0]                 wb_idx,
    output logic [31:0]                wb_data,
    output logic                       done,
    output logic                       skipped,
    input  logic                       flags_load,
    input  logic [3:0]                 flags_in,
    output logic [3:0]                 flags_nzcv
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0] state;
    logic [3:0] opc_q;
    logic       s_q;
    logic [3:0] rd_q;
    logic       shc_q;

    logic       fn, fz, fc, fv;
    logic       cond_pass;
    logic       is_test;
    logic       is_arith;
    logic       flag_upd;
    logic [3:0] new_flags;

    assign fn = flags_nzcv[3];
    assign fz = flags_nzcv[2];
    assign fc = flags_nzcv[1];
    assign fv = flags_nzcv[0];

    always_comb begin
        cond_pass = 1'b0;
        case (req.req_cond)
            4'h0: cond_pass = fz;
            4'h1: cond_pass = !fz;
            4'h2: cond_pass = fc;
            4'h3: cond_pass = !fc;
            4'h4: cond_pass = fn;
            4'h5: cond_pass = !fn;
            4'h6: cond_pass = fv;
            4'h7: cond_pass = !fv;
            4'h8: cond_pass = fc && !fz;
            4'h9: cond_pass = !fc || fz;
            4'hA: cond_pass = (fn == fv);
            4'hB: cond_pass = (fn != fv);
            4'hC: cond_pass = !fz && (fn == fv);
            4'hD: cond_pass = fz || (fn != fv);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // TST/TEQ/CMP/CMN (8-11) only touch flags; arithmetic class takes C and V from the ALU
    assign is_test   = (opc_q[3:2] == 2'b10);
    assign is_arith  = ((opc_q >= 4'd2) && (opc_q <= 4'd7)) || (opc_q == 4'd10) || (opc_q == 4'd11);
    assign flag_upd  = s_q || is_test;
    assign new_flags = is_arith ? {alu_n, alu_z, alu_c, alu_v}
                                : {alu_n, alu_z, shc_q, fv};

    assign req.req_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            opc_q    <= 4'd0;
            s_q      <= 1'b0;
            rd_q     <= 4'd0;
            shc_q    <= 1'b0;
            alu_op   <= 5'd0;
            alu_a    <= 32'd0;
            alu_b    <= 32'd0;
            alu_cin  <= 1'b0;
            wb_valid <= 1'b0;
            wb_idx   <= 4'd0;
            wb_data  <= 32'd0;
            done     <= 1'b0;
            skipped  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            done     <= 1'b0;
            skipped  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.req_valid) begin
                        if (cond_pass) begin
                            opc_q   <= req.req_opcode;
                            s_q     <= req.req_s;
                            rd_q    <= req.req_rd;
                            shc_q   <= req.req_shc;
                            alu_op  <= {1'b0, req.req_opcode};
                            alu_a   <= req.req_rn;
                            alu_b   <= req.req_op2;
                            alu_cin <= fc;
                            state   <= S_EXEC;
                        end else begin
                            skipped <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    wb_data  <= alu_result;
                    wb_idx   <= rd_q;
                    wb_valid <= !is_test;
                    done     <= 1'b1;
                    state    <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Flags change at the edge that ends EXEC so they are already visible in the WB cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_nzcv <= 4'b0000;
        end else if (flags_load) begin
            flags_nzcv <= flags_in;
        end else if ((state == S_EXEC) && flag_upd) begin
            flags_nzcv <= new_flags;
        end
    end

endmodule

// File: tb/tb_alu_dp_controller.sv
// tb/tb_alu_dp_controller.sv - randomized bench for alu_dp_controller with ALU and flag reference model
module tb_alu_dp_controller;

    logic        clk;
    logic        reset_n;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done, skipped;
    logic        flags_load;
    logic [3:0]  flags_in;
    logic [3:0]  flags_nzcv;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  mflags;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    logic        m_cin;

    alu_dp_controller_if req_if ();

    alu_dp_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req_if),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .done       (done),
        .skipped    (skipped),
        .flags_load (flags_load),
        .flags_in   (flags_in),
        .flags_nzcv (flags_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {v, c, sum}: plain 33-bit addition with signed-overflow detection
    function automatic logic [33:0] addc(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        v = (x[31] == y[31]) && (s[31] != x[31]);
        return {v, s[32], s[31:0]};
    endfunction

    // ARM ALU behaviour, returns {n, z, c, v, result}; logical ops report c=v=0
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
        logic [33:0] t;
        logic [31:0] r;
        logic        c, v;
        t = 34'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0, 4'd8:  r = a & b;
            4'd1, 4'd9:  r = a ^ b;
            4'd12:       r = a | b;
            4'd13:       r = b;
            4'd14:       r = a & ~b;
            4'd15:       r = ~b;
            4'd2, 4'd10: t = addc(a, ~b, 1'b1);
            4'd3:        t = addc(b, ~a, 1'b1);
            4'd4, 4'd11: t = addc(a, b, 1'b0);
            4'd5:        t = addc(a, b, ci);
            4'd6:        t = addc(a, ~b, ci);
            default:     t = addc(b, ~a, ci);
        endcase
        if (op inside {[4'd2:4'd7], 4'd10, 4'd11}) {v, c, r} = t;
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_fn(alu_op[3:0], alu_a, alu_b, alu_cin);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c & !z;
            4'h9: return !c | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_flags(input logic [3:0] v);
        flags_load = 1'b1;
        flags_in   = v;
        @(negedge clk);
        flags_load = 1'b0;
        mflags     = v;
        check("load_flags", flags_nzcv, mflags);
    endtask

    // ld_at: 0 none, 1 with the accept edge, 2 during EXEC, 3 during WB
    task automatic issue(input logic [3:0] cond, input logic [3:0] opc, input logic s,
                         input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2,
                         input logic shc, input int ld_at, input logic [3:0] ld_val);
        logic        pass, wb_exp, upd;
        logic [3:0]  f_old;
        logic [35:0] r;
        check("ready_idle", req_if.req_ready, 1);
        req_if.req_valid  = 1'b1;
        req_if.req_cond   = cond;
        req_if.req_opcode = opc;
        req_if.req_s      = s;
        req_if.req_rd     = rd;
        req_if.req_rn     = rn;
        req_if.req_op2    = op2;
        req_if.req_shc    = shc;
        if (ld_at == 1) begin
            flags_load = 1'b1;
            flags_in   = ld_val;
        end
        f_old = mflags;
        pass  = cond_ok(cond, f_old);
        @(posedge clk);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        flags_load       = 1'b0;
        if (ld_at == 1) mflags = ld_val;
        if (!pass) begin
            check("skip_pulse", skipped, 1);
            check("skip_done", done, 0);
            check("skip_wb", wb_valid, 0);
            check("skip_ready", req_if.req_ready, 1);
            check("skip_flags", flags_nzcv, mflags);
            check("skip_alu_op", alu_op, m_op);
            check("skip_alu_a", alu_a, m_a);
        end else begin
            m_op = {1'b0, opc}; m_a = rn; m_b = op2; m_cin = f_old[1];
            check("exec_alu_op", alu_op, m_op);
            check("exec_alu_a", alu_a, m_a);
            check("exec_alu_b", alu_b, m_b);
            check("exec_alu_cin", alu_cin, m_cin);
            check("exec_ready", req_if.req_ready, 0);
            check("exec_pulses", {skipped, done, wb_valid}, 0);
            check("exec_flags", flags_nzcv, mflags);
            if (ld_at == 2) begin
                flags_load = 1'b1;
                flags_in   = ld_val;
            end
            r      = alu_fn(opc, rn, op2, f_old[1]);
            wb_exp = !(opc inside {[4'd8:4'd11]});
            upd    = s || (opc inside {[4'd8:4'd11]});
            if (ld_at == 2) mflags = ld_val;
            else if (upd) begin
                if (opc inside {[4'd2:4'd7], 4'd10, 4'd11}) mflags = r[35:32];
                else mflags = {r[35], r[34], shc, mflags[0]};
            end
            @(negedge clk);
            flags_load = 1'b0;
            check("wb_done", done, 1);
            check("wb_valid", wb_valid, wb_exp);
            if (wb_exp) begin
                check("wb_idx", wb_idx, rd);
                check("wb_data", wb_data, r[31:0]);
            end
            check("wb_flags", flags_nzcv, mflags);
            check("wb_skipped", skipped, 0);
            check("wb_ready", req_if.req_ready, 0);
            if (ld_at == 3) begin
                flags_load = 1'b1;
                flags_in   = ld_val;
            end
            @(negedge clk);
            flags_load = 1'b0;
            if (ld_at == 3) mflags = ld_val;
            check("post_ready", req_if.req_ready, 1);
            check("post_pulses", {skipped, done, wb_valid}, 0);
            check("post_flags", flags_nzcv, mflags);
            check("post_alu_op", alu_op, m_op);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        flags_load = 1'b0;
        flags_in = 4'd0;
        req_if.req_valid = 1'b0;
        req_if.req_cond = 4'd0;
        req_if.req_opcode = 4'd0;
        req_if.req_s = 1'b0;
        req_if.req_rd = 4'd0;
        req_if.req_rn = 32'd0;
        req_if.req_op2 = 32'd0;
        req_if.req_shc = 1'b0;
        mflags = 4'd0; m_op = 5'd0; m_a = 32'd0; m_b = 32'd0; m_cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_alu", {alu_op, alu_cin}, 0);
        check("rst_wb", {wb_valid, done, skipped, wb_idx}, 0);
        check("rst_flags", flags_nzcv, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", req_if.req_ready, 1);

        // ADDS 0xFFFFFFFF + 1 -> 0 with Z and C
        issue(4'hE, 4'd4, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 4'd0);
        check("adds_flags", flags_nzcv, 4'b0110);
        // CMP 5,5 with S=0 still updates flags, no write-back
        issue(4'hE, 4'd10, 1'b0, 4'd7, 32'd5, 32'd5, 1'b0, 0, 4'd0);
        check("cmp_flags", flags_nzcv, 4'b0110);
        load_flags(4'b0000);
        issue(4'h0, 4'd13, 1'b0, 4'd2, 32'd9, 32'h1234, 1'b0, 0, 4'd0);
        load_flags(4'b0100);
        issue(4'h0, 4'd13, 1'b0, 4'd2, 32'd9, 32'h1234, 1'b0, 0, 4'd0);
        load_flags(4'b0010);
        issue(4'hE, 4'd5, 1'b0, 4'd1, 32'd1, 32'd2, 1'b0, 0, 4'd0);
        check("adc_data", wb_data, 32'd4);
        load_flags(4'b0001);
        issue(4'hE, 4'd0, 1'b1, 4'd4, 32'h8000_0000, 32'h8000_0001, 1'b1, 3, 4'b0000);
        check("ands_ld_wb", flags_nzcv, 4'b0000);
        load_flags(4'b0001);
        issue(4'hE, 4'd0, 1'b1, 4'd4, 32'h8000_0000, 32'h8000_0001, 1'b1, 2, 4'b0000);
        // back-to-back never-condition skips
        for (int i = 0; i < 3; i++) issue(4'hF, 4'd4, 1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 0, 4'd0);

        // reset mid-EXEC discards the instruction
        load_flags(4'b1010);
        req_if.req_valid = 1'b1; req_if.req_cond = 4'hE; req_if.req_opcode = 4'd4;
        req_if.req_s = 1'b1; req_if.req_rd = 4'd5; req_if.req_rn = 32'd1; req_if.req_op2 = 32'd2;
        @(posedge clk);
        @(negedge clk);
        req_if.req_valid = 1'b0;
        check("rst_mid_exec_op", alu_op, 5'b00100);
        reset_n = 1'b0;
        #1;
        check("rst_mid_alu", {alu_op, alu_cin}, 0);
        check("rst_mid_a", alu_a, 0);
        check("rst_mid_b", alu_b, 0);
        check("rst_mid_pulses", {wb_valid, done, skipped, wb_idx}, 0);
        check("rst_mid_data", wb_data, 0);
        check("rst_mid_flags", flags_nzcv, 0);
        @(negedge clk);
        check("rst_mid_nowb", wb_valid, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", req_if.req_ready, 1);
        check("rst_rel_out", {wb_valid, done, flags_nzcv}, 0);
        mflags = 4'd0; m_op = 5'd0; m_a = 32'd0; m_b = 32'd0; m_cin = 1'b0;

        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [31:0] rn, op2;
            sel = $urandom_range(0, 7);
            rn  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            op2 = ($urandom_range(0, 5) == 0) ? rn : $urandom;
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom),
                  4'($urandom), rn, op2, 1'($urandom),
                  (sel <= 4) ? 0 : sel - 4, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dp_controller.md
# alu_dp_controller

Sequencing controller for the 32-bit ARM ALU (`ALU_32Bit`). It accepts one decoded ARM data-processing instruction at a time over a valid/ready handshake and evaluates its condition field against the architectural NZCV flags. Instructions that pass are driven into the ALU, and the controller then writes back the result and updates the flags per the S bit and the opcode class. It sits between the decode stage and the register-file write port and owns the NZCV flag register.

## Interface
- No parameters; all widths fixed: data 32, opcode 4, cond 4, register index 4.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: instruction handshake.
- `req_cond` in 4, `req_opcode` in 4, `req_s` in 1, `req_rd` in 4: instruction fields.
- `req_rn` in 32 and `req_op2` in 32: operand values. `req_shc` in 1: shifter carry-out.
- `alu_op` out 5, `alu_a` out 32, `alu_b` out 32, `alu_cin` out 1: registered drive to the ALU.
- `alu_result` in 32, `alu_z`/`alu_n`/`alu_c`/`alu_v` in 1: ALU outputs.
- `wb_valid` out 1, `wb_idx` out 4, `wb_data` out 32: register write-back.
- `done` out 1: one-cycle pulse when an executed instruction retires.
- `skipped` out 1: one-cycle pulse when a condition fails.
- `flags_load` in 1, `flags_in` in 4: external NZCV write (MSR path).
- `flags_nzcv` out 4: architectural flags, bits {N,Z,C,V}.

## Operation
- FSM states: IDLE, EXEC, WB. `req_ready` is 1 only in IDLE.
- IDLE, `req_valid`=1 at an edge:
  - Evaluate the condition against the current `flags_nzcv`: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1. Cond 1111 is never (fails).
  - Fail: stay in IDLE and pulse `skipped` in the next cycle. ALU drive, flags and write-back are untouched.
  - Pass: register the fields, load `alu_op`={1'b0, opcode}, `alu_a`=rn, `alu_b`=op2, `alu_cin`=flags C, then go to EXEC.
- EXEC: ALU inputs are held stable. At the end of the cycle, capture `alu_result` and the flags, then go to WB.
- WB (one cycle):
  - `done`=1.
  - `wb_valid`=1 unless the opcode is 8–11 (TST/TEQ/CMP/CMN). `wb_idx`=rd, `wb_data`=captured result.
  - Flags are updated if `req_s`=1 or the opcode is 8–11.
  - Arithmetic opcodes (2–7, 10, 11): N, Z, C and V are taken from the ALU.
  - Logical opcodes (0, 1, 8, 9, 12–15): N and Z from the ALU, C from the latched `req_shc`, V unchanged.
  - Return to IDLE.
- `flags_load`=1 writes `flags_in` at any edge. If it coincides with the WB flag update, `flags_load` wins.
- A request accepted in the same cycle as `flags_load` evaluates its condition against the old flags.
- Outside EXEC, `alu_*` hold their last values.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - State IDLE.
  - `req_ready`=1 once reset is released.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0, `alu_cin`=0.
  - `wb_valid`=0, `wb_idx`=0, `wb_data`=0, `done`=0, `skipped`=0.
  - `flags_nzcv`=0000.
- Reset mid-operation discards the instruction: no write-back, no flag update.
- Executed instruction accepted at edge 0:
  - ALU driven during cycle 1.
  - `wb_valid`/`done` high during cycle 2; new flags visible from cycle 2.
  - `req_ready` high again in cycle 3.
  - Throughput is one instruction per 3 cycles.
- Skipped instruction accepted at edge 0: `skipped` high in cycle 1 and `req_ready` stays 1. Back-to-back skips are accepted every cycle.
- `wb_valid`, `done` and `skipped` are single-cycle pulses and are mutually exclusive.
- Arithmetic is fully delegated to the ALU; the controller does no width extension.

## Test plan
- Reset: assert `reset_n`=0 mid-EXEC of an ADD -> all outputs zero, `flags_nzcv`=0000, no `wb_valid`; after release `req_ready`=1.
- ADD (0100), AL, S=1, rn=0xFFFFFFFF, op2=1, rd=3 -> `alu_op`=00100 in cycle 1; cycle 2 `wb_valid`=1, `wb_idx`=3, `wb_data`=0; flags N=0, Z=1, C=1.
- CMP (1010), AL, S=0, rn=5, op2=5 -> `done`=1 and `wb_valid`=0 in cycle 2; Z=1 and C=1 per the ALU.
- MOV (1101), EQ, with Z=0 -> `skipped`=1 in cycle 1, no ALU activity, flags unchanged. Load flags 0100 via `flags_load`, reissue -> executes, `wb_valid`=1.
- ADC (0101), AL, flags C=1, rn=1, op2=2 -> `alu_cin`=1, `wb_data`=4.
- ANDS (0000), S=1, `req_shc`=1, rn=0x80000000, op2=0x80000001 -> `wb_data`=0x80000000; flags N=1, Z=0, C=1, V=prior. Assert `flags_load` with 0000 in the WB cycle -> `flags_nzcv`=0000.
